// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU command sequencer: ALU op codes,
//   positions of the {N,Z,C,V} flag bits, and the sequencer state encoding.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_CONV = 3'b101;
    localparam logic [2:0] OP_RSV6 = 3'b110;
    localparam logic [2:0] OP_RSV7 = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RETIRE = 2'd2
    } seq_state_t;

    function automatic logic op_reserved(input logic [2:0] op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile
//   NREGS x WIDTH register file with three combinational read ports.
//   It has one write port made of two enable/address/data lanes: the
//   writeback lane and the host load lane. The sequencer decides which
//   lanes fire (it drops a load that hits the writeback address), so at most
//   one lane targets any given register on a clock edge.
// Ports
//   clk, reset                 clock, synchronous active-high reset (clears all)
//   wb_en/wb_addr/wb_data      writeback lane
//   ld_en/ld_addr/ld_data      host load lane
//   rn_addr/rn_data            read port for operand a
//   rm_addr/rm_data            read port for operand b
//   rd_addr/rd_data            host read port
module alu_regfile #(
    parameter int WIDTH = 5,
    parameter int NREGS = 4,
    parameter int RAW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_en,
    input  logic [RAW-1:0]   wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [RAW-1:0]   ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [RAW-1:0]   rn_addr,
    input  logic [RAW-1:0]   rm_addr,
    input  logic [RAW-1:0]   rd_addr,
    output logic [WIDTH-1:0] rn_data,
    output logic [WIDTH-1:0] rm_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) regs[ld_addr] <= ld_data;
            if (wb_en) regs[wb_addr] <= wb_data;
        end
    end

    assign rn_data = regs[rn_addr];
    assign rm_data = regs[rm_addr];
    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue/writeback stage for an external combinational ALU. Accepts one
//   command per valid/ready handshake, reads operands from a local register
//   file, presents them to the ALU for one EXEC cycle, writes Result back and
//   optionally latches ALUFlags, then pulses done (or err for reserved ops).
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_*               command handshake and fields (op, rd, rn, rm, imm, ...)
//   a, b, ALUControl,   registered ALU drive; hold until the next accept
//   shift_input, direction
//   Result, ALUFlags    ALU response
//   flags_q             architectural {N,Z,C,V}
//   done, err           one-cycle retire pulses
//   load_*              host write port
//   rd_addr, rd_data    host combinational read port
//
// state    | meaning
// S_IDLE   | cmd_ready=1, waiting for a command
// S_EXEC   | ALU evaluating latched operands; writeback on exit edge
// S_RETIRE | done or err pulse high for this cycle
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NREGS = 4,
    parameter int RAW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_rd,
    input  logic [RAW-1:0]   cmd_rn,
    input  logic [RAW-1:0]   cmd_rm,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    input  logic             cmd_setflags,
    input  logic [1:0]       cmd_shift,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [2:0]       ALUControl,
    output logic [1:0]       shift_input,
    output logic             direction,
    input  logic [WIDTH-1:0] Result,
    input  logic [3:0]       ALUFlags,
    output logic [3:0]       flags_q,
    output logic             done,
    output logic             err,
    input  logic             load_en,
    input  logic [RAW-1:0]   load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [RAW-1:0]   rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    seq_state_t       state;
    logic [RAW-1:0]   rd_q;
    logic             setflags_q;
    logic [WIDTH-1:0] rn_data;
    logic [WIDTH-1:0] rm_data;
    logic             wb_en;
    logic             ld_we;

    assign cmd_ready = (state == S_IDLE) && !reset;

    // Writeback takes priority: a host load to the same register on the
    // writeback edge is dropped, loads elsewhere still land.
    assign wb_en = (state == S_EXEC) && !op_reserved(ALUControl);
    assign ld_we = load_en && !(wb_en && (load_addr == rd_q));

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (Result),
        .ld_en   (ld_we),
        .ld_addr (load_addr),
        .ld_data (load_data),
        .rn_addr (cmd_rn),
        .rm_addr (cmd_rm),
        .rd_addr (rd_addr),
        .rn_data (rn_data),
        .rm_data (rm_data),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            a           <= '0;
            b           <= '0;
            ALUControl  <= '0;
            shift_input <= '0;
            direction   <= 1'b0;
            rd_q        <= '0;
            setflags_q  <= 1'b0;
            flags_q     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Operands come from the pre-edge register contents, so a
                    // same-edge host load to rn/rm is not seen by this command.
                    if (cmd_valid) begin
                        a           <= rn_data;
                        b           <= cmd_imm_en ? cmd_imm : rm_data;
                        ALUControl  <= cmd_op;
                        shift_input <= cmd_shift;
                        direction   <= cmd_dir;
                        rd_q        <= cmd_rd;
                        setflags_q  <= cmd_setflags;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_reserved(ALUControl)) begin
                        err <= 1'b1;
                    end else begin
                        done <= 1'b1;
                        if (setflags_q) flags_q <= ALUFlags;
                    end
                    state <= S_RETIRE;
                end
                S_RETIRE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int WIDTH = 5;
    localparam int NREGS = 4;
    localparam int RAW   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [RAW-1:0]   cmd_rd, cmd_rn, cmd_rm;
    logic             cmd_imm_en;
    logic [WIDTH-1:0] cmd_imm;
    logic             cmd_setflags;
    logic [1:0]       cmd_shift;
    logic             cmd_dir;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       ALUControl;
    logic [1:0]       shift_input;
    logic             direction;
    logic [WIDTH-1:0] Result;
    logic [3:0]       ALUFlags;
    logic [3:0]       flags_q;
    logic             done, err;
    logic             load_en;
    logic [RAW-1:0]   load_addr;
    logic [WIDTH-1:0] load_data;
    logic [RAW-1:0]   rd_addr;
    logic [WIDTH-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS), .RAW(RAW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rn       (cmd_rn),
        .cmd_rm       (cmd_rm),
        .cmd_imm_en   (cmd_imm_en),
        .cmd_imm      (cmd_imm),
        .cmd_setflags (cmd_setflags),
        .cmd_shift    (cmd_shift),
        .cmd_dir      (cmd_dir),
        .a            (a),
        .b            (b),
        .ALUControl   (ALUControl),
        .shift_input  (shift_input),
        .direction    (direction),
        .Result       (Result),
        .ALUFlags     (ALUFlags),
        .flags_q      (flags_q),
        .done         (done),
        .err          (err),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    // Stand-in 5-bit ALU beside the sequencer (shift/direction not modelled).
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                alu_sum = {1'b0, a} + {1'b0, b};
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_sum = {1'b0, a} + {1'b0, ~b} + 6'd1;
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_CONV: alu_res = ~a + 5'd1;
            default: alu_res = '0;
        endcase
        Result   = alu_res;
        ALUFlags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
    end

    typedef struct {
        logic [2:0]       op;
        logic [RAW-1:0]   rd, rn, rm;
        logic             imm_en;
        logic [WIDTH-1:0] imm;
        logic             sf;
        logic [1:0]       shift;
        logic             dir;
        logic [1:0]       ld_when;   // 0 none, 1 accept cycle, 2 EXEC cycle, 3 before command
        logic [RAW-1:0]   ld_addr;
        logic [WIDTH-1:0] ld_data;
        logic [WIDTH-1:0] exp_a, exp_b, exp_rd;
        logic [3:0]       exp_flags;
        logic             exp_err;
        logic [RAW-1:0]   chk_addr;
        logic [WIDTH-1:0] chk_val;
    } vec_t;

    function automatic vec_t mk(input int op, rd, rn, rm, ie, imm, sf, sh, dir,
                                input int ldw, lda, ldd,
                                input int ea, eb, erd, ef, eerr, ca, cv);
        vec_t v;
        v.op = 3'(op);   v.rd = 2'(rd);   v.rn = 2'(rn);   v.rm = 2'(rm);
        v.imm_en = 1'(ie); v.imm = 5'(imm); v.sf = 1'(sf);
        v.shift = 2'(sh); v.dir = 1'(dir);
        v.ld_when = 2'(ldw); v.ld_addr = 2'(lda); v.ld_data = 5'(ldd);
        v.exp_a = 5'(ea); v.exp_b = 5'(eb); v.exp_rd = 5'(erd);
        v.exp_flags = 4'(ef); v.exp_err = 1'(eerr);
        v.chk_addr = 2'(ca); v.chk_val = 5'(cv);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input int addr, input int data);
        load_en   = 1'b1;
        load_addr = 2'(addr);
        load_data = 5'(data);
        tick();
        load_en   = 1'b0;
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_op = v.op;  cmd_rd = v.rd;  cmd_rn = v.rn;  cmd_rm = v.rm;
        cmd_imm_en = v.imm_en;  cmd_imm = v.imm;  cmd_setflags = v.sf;
        cmd_shift = v.shift;  cmd_dir = v.dir;
        cmd_valid = 1'b1;
    endtask

    // Runs one command from IDLE back to IDLE and checks every stage.
    task automatic do_cmd(input string tag, input vec_t v);
        logic [3:0] flags_exec;
        if (v.ld_when == 2'd3) ld(v.ld_addr, v.ld_data);
        chk({tag, " ready_idle"}, cmd_ready, 1);
        drive_cmd(v);
        if (v.ld_when == 2'd1) begin
            load_en = 1'b1; load_addr = v.ld_addr; load_data = v.ld_data;
        end
        tick();
        cmd_valid = 1'b0;
        load_en   = 1'b0;
        // EXEC
        chk({tag, " a"}, a, v.exp_a);
        chk({tag, " b"}, b, v.exp_b);
        chk({tag, " ctrl"}, ALUControl, v.op);
        chk({tag, " shift"}, shift_input, v.shift);
        chk({tag, " dir"}, direction, v.dir);
        chk({tag, " ready_busy"}, cmd_ready, 0);
        chk({tag, " done_exec"}, done, 0);
        flags_exec = ALUFlags;
        if (v.ld_when == 2'd2) begin
            load_en = 1'b1; load_addr = v.ld_addr; load_data = v.ld_data;
        end
        tick();
        load_en = 1'b0;
        // RETIRE
        chk({tag, " done"}, done, !v.exp_err);
        chk({tag, " err"}, err, v.exp_err);
        chk({tag, " flags"}, flags_q, v.exp_flags);
        if (v.sf && !v.exp_err) chk({tag, " flags_vs_alu"}, flags_q, flags_exec);
        rd_addr = v.rd;
        #1;
        chk({tag, " reg_rd"}, rd_data, v.exp_rd);
        rd_addr = v.chk_addr;
        #1;
        chk({tag, " reg_chk"}, rd_data, v.chk_val);
        tick();
        // IDLE again
        chk({tag, " ready_back"}, cmd_ready, 1);
        chk({tag, " done_low"}, done, 0);
        chk({tag, " err_low"}, err, 0);
    endtask

    vec_t tbl[10];
    vec_t col[3];
    int   accepts;
    int   acc_idx;

    initial begin
        // op rd rn rm ie imm sf sh dir | ldw lda ldd | ea eb erd ef eerr | ca cv
        tbl[0] = mk(0, 3, 1, 2, 0,  0, 0, 0, 0,  0, 0, 0,   3,  5,  8, 4'b0000, 0,  3,  8);
        tbl[1] = mk(1, 1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0,   5,  5,  0, 4'b0110, 0,  1,  0);
        tbl[2] = mk(2, 2, 0, 3, 1,  1, 0, 0, 0,  3, 0, 8,   8,  1,  0, 4'b0110, 0,  0,  8);
        tbl[3] = mk(4, 0, 0, 0, 1, 31, 1, 2, 1,  0, 0, 0,   8, 31, 23, 4'b1000, 0,  0, 23);
        tbl[4] = mk(3, 1, 1, 3, 0,  0, 0, 1, 0,  0, 0, 0,   0,  8,  8, 4'b1000, 0,  1,  8);
        tbl[5] = mk(0, 2, 3, 0, 1,  8, 1, 0, 0,  0, 0, 0,   8,  8, 16, 4'b1001, 0,  2, 16);
        tbl[6] = mk(0, 0, 2, 0, 1, 16, 1, 0, 0,  0, 0, 0,  16, 16,  0, 4'b0111, 0,  0,  0);
        tbl[7] = mk(5, 3, 1, 0, 0,  0, 1, 0, 0,  0, 0, 0,   8,  0, 24, 4'b1000, 0,  3, 24);
        tbl[8] = mk(6, 3, 1, 2, 0,  0, 1, 3, 1,  0, 0, 0,   8, 16, 24, 4'b1000, 1,  3, 24);
        tbl[9] = mk(7, 0, 3, 0, 1,  5, 0, 0, 0,  0, 0, 0,  24,  5,  0, 4'b1000, 1,  0,  0);
        // load collisions: same address (dropped), other address, accept-cycle load
        col[0] = mk(0, 3, 1, 0, 1,  1, 0, 0, 0,  2, 3, 31,  8,  1,  9, 4'b1000, 0,  3,  9);
        col[1] = mk(0, 3, 1, 0, 1,  2, 0, 0, 0,  2, 1, 15,  8,  2, 10, 4'b1000, 0,  1, 15);
        col[2] = mk(0, 2, 1, 0, 1,  0, 0, 0, 0,  1, 1,  7, 15,  0, 15, 4'b1000, 0,  1,  7);

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; cmd_setflags = 1'b0; cmd_shift = '0; cmd_dir = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;

        repeat (3) tick();
        chk("rst ready", cmd_ready, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst a", a, 0);
        chk("rst b", b, 0);
        chk("rst ctrl", ALUControl, 0);
        chk("rst flags", flags_q, 0);
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = 2'(i);
            #1;
            chk($sformatf("rst reg%0d", i), rd_data, 0);
        end
        reset = 1'b0;
        #1;
        chk("rst release ready", cmd_ready, 1);
        tick();

        ld(0, 5);
        ld(1, 3);
        ld(2, 5);
        for (int i = 0; i < 10; i++) do_cmd($sformatf("vec%0d", i), tbl[i]);
        for (int i = 0; i < 3; i++) do_cmd($sformatf("col%0d", i), col[i]);

        // Reset during EXEC abandons the command.
        drive_cmd(mk(0, 3, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        cmd_valid = 1'b0;
        chk("midrst busy", cmd_ready, 0);
        reset = 1'b1;
        tick();
        chk("midrst ready_in_reset", cmd_ready, 0);
        chk("midrst done", done, 0);
        chk("midrst err", err, 0);
        reset = 1'b0;
        #1;
        chk("midrst ready_after", cmd_ready, 1);
        rd_addr = 2'd3;
        #1;
        chk("midrst r3", rd_data, 0);
        chk("midrst flags", flags_q, 0);
        tick();
        chk("midrst no_late_done", done, 0);

        // Command held valid while busy: accepted exactly once, first IDLE cycle.
        ld(1, 3);
        ld(2, 5);
        drive_cmd(mk(0, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive_cmd(mk(1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        accepts = 0;
        acc_idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (cmd_valid && cmd_ready) begin
                accepts++;
                acc_idx = i;
            end
            tick();
            if (accepts > 0) begin
                cmd_valid = 1'b0;
                break;
            end
        end
        chk("hold accepts", accepts, 1);
        chk("hold accept_cycle", acc_idx, 2);
        chk("hold a", a, 5);
        chk("hold b", b, 3);
        tick();
        chk("hold done", done, 1);
        rd_addr = 2'd0;
        #1;
        chk("hold r0", rd_data, 2);
        rd_addr = 2'd3;
        #1;
        chk("hold r3", rd_data, 8);
        tick();
        chk("hold ready_back", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
